// File: rtl/cordic_hyp_pkg.sv
// cordic_hyp_pkg: constants shared by the hyperbolic CORDIC blocks (Q16 angles, shift schedule, gain correction)
package cordic_hyp_pkg;
  localparam int GUARD = 4;
  localparam int ZW = 20;
  localparam int THETA_MAX = 73282;
  // indices 4 and 13 repeat so the hyperbolic iteration converges
  localparam int SHIFT_SEQ [0:15] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
  localparam int ATANH [1:14] = '{35999, 16739, 8235, 4101, 2049, 1024, 512, 256, 128, 64, 32, 16, 8, 4};
  localparam int INV_KH [8:16] = '{79133, 79134, 79134, 79134, 79134, 79134, 79134, 79134, 79134};
endpackage

// File: rtl/cordic_atanh_vectoring_if.sv
// cordic_atanh_vectoring_if: sample-in / result-out bundle of the atanh vectoring pipeline
interface cordic_atanh_vectoring_if #(parameter int WI = 8);
  logic signed [WI+15:0] x;
  logic signed [WI+15:0] y;
  logic pre_vaild;
  logic signed [17:0] theta;
  logic signed [WI+15:0] mag;
  logic err;
  logic post_vaild;
  modport master(output x, y, pre_vaild, input theta, mag, err, post_vaild);
  modport slave(input x, y, pre_vaild, output theta, mag, err, post_vaild);
endinterface

// File: rtl/cordic_hyp_vec_stage.sv
// cordic_hyp_vec_stage: one registered hyperbolic vectoring micro-rotation driving y toward zero
module cordic_hyp_vec_stage #(
  parameter int W = 28,
  parameter int ZW = 20,
  parameter int SHIFT = 1,
  parameter int ANGLE = 35999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic i_v,
  input  logic i_e,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic signed [ZW-1:0] o_z,
  output logic o_v,
  output logic o_e
);
  localparam logic signed [ZW-1:0] A = ZW'(ANGLE);
  logic signed [W-1:0] w_xs, w_ys;
  logic w_neg;
  assign w_neg = i_y[W-1];
  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_x <= '0;
      o_y <= '0;
      o_z <= '0;
      o_v <= 1'b0;
      o_e <= 1'b0;
    end else begin
      o_x <= w_neg ? i_x + w_ys : i_x - w_ys;
      o_y <= w_neg ? i_y + w_xs : i_y - w_xs;
      o_z <= w_neg ? i_z - A : i_z + A;
      o_v <= i_v;
      o_e <= i_e;
    end
endmodule

// File: rtl/cordic_atanh_vectoring.sv
// cordic_atanh_vectoring: pipelined hyperbolic CORDIC, (x, y) -> atanh(y/x) and sqrt(x^2 - y^2)
module cordic_atanh_vectoring
  import cordic_hyp_pkg::*;
#(
  parameter int WI = 8,
  parameter int PIPELINE = 16
) (
  input logic clk,
  input logic rst_n,
  cordic_atanh_vectoring_if.slave bus
);
  localparam int N = WI + 16;
  localparam int W = N + GUARD;
  localparam int PW = W + 19;
  localparam logic signed [PW-1:0] INV = PW'(INV_KH[PIPELINE]);
  localparam logic signed [ZW-1:0] ZMAX = ZW'(THETA_MAX);
  logic signed [N:0] w_ax, w_sy, w_ay, w_lim;
  logic w_dom;
  logic signed [W-1:0] r_x0, r_y0;
  logic r_v0, r_e0;
  logic signed [W-1:0] w_x [PIPELINE+1];
  logic signed [W-1:0] w_y [PIPELINE+1];
  logic signed [ZW-1:0] w_z [PIPELINE+1];
  logic w_v [PIPELINE+1];
  logic w_e [PIPELINE+1];
  logic signed [PW-1:0] w_prod, w_rnd;
  logic signed [W+2:0] w_m;
  logic signed [N-1:0] w_mag;
  logic signed [ZW-1:0] w_zs;
  logic w_ovf, w_unused;
  logic signed [17:0] r_theta;
  logic signed [N-1:0] r_mag;
  logic r_err, r_pv;
  // |y| > x - x/8 - x/16 - x/128 approximates |y|/x > tanh(theta_max)
  assign w_ax = {bus.x[N-1], bus.x};
  assign w_sy = {bus.y[N-1], bus.y};
  assign w_ay = w_sy[N] ? -w_sy : w_sy;
  assign w_lim = w_ax - (w_ax >>> 3) - (w_ax >>> 4) - (w_ax >>> 7);
  assign w_dom = w_ax[N] || (w_ax == '0) || (w_ay >= w_ax) || (w_ay > w_lim);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_v0 <= 1'b0;
      r_e0 <= 1'b0;
    end else begin
      r_x0 <= W'(bus.x);
      r_y0 <= W'(bus.y);
      r_v0 <= bus.pre_vaild;
      r_e0 <= bus.pre_vaild & w_dom;
    end
  assign w_x[0] = r_x0;
  assign w_y[0] = r_y0;
  assign w_z[0] = '0;
  assign w_v[0] = r_v0;
  assign w_e[0] = r_e0;
  genvar k;
  for (k = 0; k < PIPELINE; k++) begin : g_stage
    cordic_hyp_vec_stage #(
      .W(W),
      .ZW(ZW),
      .SHIFT(SHIFT_SEQ[k]),
      .ANGLE(ATANH[SHIFT_SEQ[k]])
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .i_x(w_x[k]),
      .i_y(w_y[k]),
      .i_z(w_z[k]),
      .i_v(w_v[k]),
      .i_e(w_e[k]),
      .o_x(w_x[k+1]),
      .o_y(w_y[k+1]),
      .o_z(w_z[k+1]),
      .o_v(w_v[k+1]),
      .o_e(w_e[k+1])
    );
  end
  // remove the CORDIC gain with rounding, then drop guard bits with saturation
  assign w_prod = PW'(w_x[PIPELINE]) * INV;
  assign w_rnd = w_prod + PW'(32768);
  assign w_m = w_rnd[PW-1:16];
  assign w_ovf = w_m[W+2:N-1] != {(W+4-N){w_m[W+2]}};
  assign w_mag = w_ovf ? {w_m[W+2], {(N-1){~w_m[W+2]}}} : w_m[N-1:0];
  assign w_zs = (w_z[PIPELINE] > ZMAX) ? ZMAX : (w_z[PIPELINE] < -ZMAX) ? -ZMAX : w_z[PIPELINE];
  assign w_unused = ^{w_rnd[15:0], w_y[PIPELINE], w_zs[ZW-1:18]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_theta <= '0;
      r_mag <= '0;
      r_err <= 1'b0;
      r_pv <= 1'b0;
    end else begin
      r_theta <= w_e[PIPELINE] ? '0 : w_zs[17:0];
      r_mag <= w_e[PIPELINE] ? '0 : w_mag;
      r_err <= w_e[PIPELINE];
      r_pv <= w_v[PIPELINE];
    end
  assign bus.theta = r_theta;
  assign bus.mag = r_mag;
  assign bus.err = r_err;
  assign bus.post_vaild = r_pv;
endmodule

// File: tb/tb_cordic_atanh_vectoring.sv
// tb_cordic_atanh_vectoring: directed vector table plus latency, bubble and reset sequences
module tb_cordic_atanh_vectoring;
  localparam int WI = 8;
  localparam int N = WI + 16;
  localparam int LAT = 18;
  localparam int NV = 12;
  typedef struct {
    int x;
    int y;
    int th;
    int mag;
    int err;
    int tol_t;
    int tol_m;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cordic_atanh_vectoring_if #(.WI(WI)) bus();
  cordic_atanh_vectoring #(.WI(WI), .PIPELINE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  bit st_v [128];
  int sx [128];
  int sy [128];
  int ov [128];
  int oe [128];
  int ot [128];
  int om [128];
  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " post_vaild"}, int'(bus.post_vaild), 0, 0);
    chk({tag, " err"}, int'(bus.err), 0, 0);
    chk({tag, " theta"}, int'(bus.theta), 0, 0);
    chk({tag, " mag"}, int'(bus.mag), 0, 0);
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n + LAT + 2; c++) begin
      @(negedge clk);
      ov[c] = int'(bus.post_vaild);
      oe[c] = int'(bus.err);
      ot[c] = int'(bus.theta);
      om[c] = int'(bus.mag);
      bus.pre_vaild = (c < n) ? st_v[c] : 1'b0;
      bus.x = (c < n) ? N'(sx[c]) : '0;
      bus.y = (c < n) ? N'(sy[c]) : '0;
    end
  endtask
  initial begin
    vec_t tbl [NV];
    bit pat [7];
    tbl[0]  = '{65536, 0, 0, 65536, 0, 8, 16};
    tbl[1]  = '{131072, -65536, -35999, 113512, 0, 8, 16};
    tbl[2]  = '{65536, 32768, 35999, 56756, 0, 8, 16};
    tbl[3]  = '{196608, 131072, 52738, 146543, 0, 8, 16};
    tbl[4]  = '{81920, 49152, 45426, 65536, 0, 8, 16};
    tbl[5]  = '{65536, 65536, 0, 0, 1, 0, 0};
    tbl[6]  = '{73900, 34151, 32768, 65536, 0, 16, 16};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{73900, -34151, -32768, 65536, 0, 16, 16};
    tbl[9]  = '{-65536, 32768, 0, 0, 1, 0, 0};
    tbl[10] = '{65536, 58982, 0, 0, 1, 0, 0};
    tbl[11] = '{65536, 32768, 35999, 56756, 0, 8, 16};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.pre_vaild = 1'b0;
    bus.x = '0;
    bus.y = '0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // single pulse: exactly one valid output, LAT clocks later
    st_v[0] = 1'b1;
    sx[0] = 65536;
    sy[0] = 32768;
    run(1);
    for (int c = 0; c < LAT + 3; c++) chk($sformatf("pulse valid c%0d", c), ov[c], int'(c == LAT), 0);
    chk("pulse theta", ot[LAT], 35999, 8);
    chk("pulse mag", om[LAT], 56756, 16);
    chk("pulse err", oe[LAT], 0, 0);
    // back-to-back table, including domain errors between good samples
    for (int i = 0; i < NV; i++) begin
      st_v[i] = 1'b1;
      sx[i] = tbl[i].x;
      sy[i] = tbl[i].y;
    end
    run(NV);
    chk("table head valid", ov[LAT-1], 0, 0);
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d valid", i), ov[i+LAT], 1, 0);
      chk($sformatf("vec%0d theta", i), ot[i+LAT], tbl[i].th, tbl[i].tol_t);
      chk($sformatf("vec%0d mag", i), om[i+LAT], tbl[i].mag, tbl[i].tol_m);
      chk($sformatf("vec%0d err", i), oe[i+LAT], tbl[i].err, 0);
    end
    chk("table tail valid", ov[NV+LAT], 0, 0);
    // bubbles reappear unchanged
    for (int i = 0; i < 7; i++) begin
      st_v[i] = pat[i];
      sx[i] = pat[i] ? 65536 : 0;
      sy[i] = pat[i] ? 32768 : 0;
    end
    run(7);
    for (int c = 0; c < LAT; c++) chk($sformatf("bubble pre c%0d", c), ov[c], 0, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bubble valid %0d", i), ov[i+LAT], int'(pat[i]), 0);
      if (pat[i]) chk($sformatf("bubble theta %0d", i), ot[i+LAT], 35999, 8);
    end
    chk("bubble tail", ov[7+LAT], 0, 0);
    // reset with a full pipe
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.pre_vaild = 1'b1;
      bus.x = N'(65536);
      bus.y = N'(32768);
    end
    @(negedge clk);
    chk("pre-reset valid", int'(bus.post_vaild), 1, 0);
    chk("pre-reset mag", int'(bus.mag), 56756, 16);
    rst_n = 1'b0;
    bus.pre_vaild = 1'b0;
    #1;
    chk_zero("async reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_zero($sformatf("reset window %0d", c));
    end
    rst_n = 1'b1;
    st_v[0] = 1'b1;
    sx[0] = 196608;
    sy[0] = 131072;
    run(1);
    for (int c = 0; c < LAT + 3; c++) chk($sformatf("post-reset valid c%0d", c), ov[c], int'(c == LAT), 0);
    chk("post-reset theta", ot[LAT], 52738, 8);
    chk("post-reset mag", om[LAT], 146543, 16);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
